lsu_mem_stage: RTL and testbench

//  MEM-stage load/store unit directly upstream of the data RAM wrapper. Takes one
//  RV32 load/store per handshake, drives the word-only RAM port (byte address,

---
 rtl/lsu_mem_stage.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit in front of a word-wide RAM with 1-cycle synchronous read.
// Word stores write directly. Byte and halfword stores use read-modify-write.
// Loads return sign- or zero-extended lane data. Bad requests complete with resp_err.
module lsu_mem_stage #(
    parameter int ADDR_W      = 16,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_wen,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LD_DATA   = 2'd1,
        RMW_MERGE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;
    logic [2:0]        funct3_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [31:0]       resp_rdata_r;

    logic              accept_s;
    logic              misalign_s;
    logic              illegal_s;
    logic              range_s;
    logic              err_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [31:0]       ram_wdata_s;
    logic              ram_wen_s;

    // Replace the byte lane (funct3 SB) or the halfword lane (funct3 SH) of a RAM word.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] off,
                                                input logic [15:0] data, input logic [2:0] f3);
        logic [31:0] res;
        res = word;
        if (f3[0] == 1'b1) begin
            if (off[1] == 1'b1) res[31:16] = data;
            else                res[15:0]  = data;
        end else begin
            case (off)
                2'd0:    res[7:0]   = data[7:0];
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                default: res[31:24] = data[7:0];
            endcase
        end
        return res;
    endfunction

    // Select the load lane and extend it according to funct3.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = (off[1] == 1'b1) ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd4:    res = {24'd0, b};
            3'd5:    res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign accept_s  = (state_r == IDLE) && req_valid;
    assign req_ready = (state_r == IDLE);

    // Classify the incoming request: misalignment, illegal funct3 and out-of-range address.
    always_comb begin
        misalign_s = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign_s = req_addr[0];
            2'b10:   misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        if (req_we) begin
            illegal_s = (req_funct3 > 3'd2);
        end else begin
            illegal_s = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
        range_s = CHECK_RANGE && (req_addr[31:ADDR_W] != {(32-ADDR_W){1'b0}});
        err_s   = misalign_s || illegal_s || range_s;
    end

    // Next-state selection for the request sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (err_s)                       state_next_s = RESP;
                    else if (!req_we)                state_next_s = LD_DATA;
                    else if (req_funct3 == 3'd2)     state_next_s = RESP;
                    else                             state_next_s = RMW_MERGE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LD_DATA:   state_next_s = RESP;
            RMW_MERGE: state_next_s = RESP;
            RESP:      state_next_s = IDLE;
            default:   state_next_s = IDLE;
        endcase
    end

    // RAM port: the live request drives it in IDLE, and the latched address drives it afterwards.
    always_comb begin
        ram_addr_s  = addr_r;
        ram_wdata_s = 32'd0;
        ram_wen_s   = 1'b0;
        case (state_r)
            IDLE: begin
                ram_addr_s  = req_addr[ADDR_W-1:0];
                ram_wdata_s = req_wdata;
                ram_wen_s   = accept_s && req_we && !err_s && (req_funct3 == 3'd2);
            end
            RMW_MERGE: begin
                ram_wdata_s = merge_store(ram_rdata, addr_r[1:0], wdata_r, funct3_r);
                ram_wen_s   = 1'b1;
            end
            default: begin
                ram_wen_s = 1'b0;
            end
        endcase
    end

    assign ram_addr  = ram_addr_s;
    assign ram_wdata = ram_wdata_s;
    // A reset that lands mid read-modify-write must never reach the RAM as a write.
    assign ram_wen   = ram_wen_s && rst_n;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    // Capture the request fields at acceptance. They are ignored while the unit is busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= 16'd0;
            funct3_r <= 3'd0;
        end else if (accept_s) begin
            addr_r   <= req_addr[ADDR_W-1:0];
            wdata_r  <= req_wdata[15:0];
            funct3_r <= req_funct3;
        end else begin
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
            funct3_r <= funct3_r;
        end
    end

    // Registered response: a one-cycle pulse whose data and error clear when it drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            resp_valid_r <= (state_next_s == RESP);
            resp_err_r   <= accept_s && err_s;
            resp_rdata_r <= (state_r == LD_DATA) ? extract_load(ram_rdata, addr_r[1:0], funct3_r)
                                                 : 32'd0;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a behavioural word RAM (1-cycle synchronous read).
module tb_lsu_mem_stage;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_wen;
    logic [31:0]       ram_rdata;

    logic [31:0] mem [0:16383];
    int          wen_cnt = 0;
    int          errors  = 0;
    int          checks  = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          wens;
        logic        mchk;
        logic [31:0] mexp;
    } vec_t;

    vec_t vecs[$];

    lsu_mem_stage #(.ADDR_W(ADDR_W), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Word RAM: write on ram_wen, registered read of the old contents.
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr[15:2]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[15:2]];
    end

    // Count every RAM write so that write-free and single-write operations can be checked.
    always @(posedge clk) begin
        if (ram_wen) wen_cnt <= wen_cnt + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                                input int lat, input int wens, input logic mchk, input logic [31:0] mexp);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
        v.lat = lat; v.wens = wens; v.mchk = mchk; v.mexp = mexp;
        return v;
    endfunction

    // One transaction, called from a negedge: wait for ready, issue, then check the response.
    task automatic do_op(input int idx, input vec_t v);
        int   n;
        int   lat;
        int   wen0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check32($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        wen0 = wen_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        check32($sformatf("v%0d_lat", idx), lat, v.lat);
        check32($sformatf("v%0d_err", idx), {31'd0, resp_err}, {31'd0, v.err});
        check32($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
        check32($sformatf("v%0d_busy", idx), {31'd0, req_ready}, 32'd0);
        check32($sformatf("v%0d_wens", idx), wen_cnt - wen0, v.wens);
        @(negedge clk);
        check32($sformatf("v%0d_vdrop", idx), {31'd0, resp_valid}, 32'd0);
        check32($sformatf("v%0d_clr", idx), {resp_err, resp_rdata[30:0]}, 32'd0);
        if (v.mchk) check32($sformatf("v%0d_mem", idx), mem[v.addr[15:2]], v.mexp);
    endtask

    initial begin
        int          wen0;
        int          k;
        int          r;
        int          acc;
        int          acc_cyc[3];
        logic [31:0] q_addr[3];
        logic [31:0] q_wdata[3];
        logic [2:0]  q_f3[3];
        logic        q_we[3];
        logic [31:0] q_exp[3];

        // Columns: we, f3, addr, wdata, err, rdata, latency, writes, check-mem, mem expected
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0, 1, 1, 1'b1, 32'hA5A5_A5A5));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 1, 1'b1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0, 1, 1, 1'b1, 32'h1122_3344));
        vecs.push_back(mk(1'b1, 3'd0, 32'h0000_0022, 32'h0000_00AA, 1'b0, 32'h0, 2, 1, 1'b1, 32'h11AA_3344));
        vecs.push_back(mk(1'b1, 3'd1, 32'h0000_0020, 32'h0000_5555, 1'b0, 32'h0, 2, 1, 1'b1, 32'h11AA_5555));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0020, 32'h0,         1'b0, 32'h11AA_5555, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0030, 32'h80FF_7F01, 1'b0, 32'h0, 1, 1, 1'b1, 32'h80FF_7F01));
        vecs.push_back(mk(1'b0, 3'd0, 32'h0000_0033, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd4, 32'h0000_0033, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd1, 32'h0000_0032, 32'h0, 1'b0, 32'hFFFF_80FF, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd5, 32'h0000_0030, 32'h0, 1'b0, 32'h0000_7F01, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd0, 32'h0000_0030, 32'h0, 1'b0, 32'h0000_0001, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0002, 32'h0,         1'b1, 32'h0, 1, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd1, 32'h0000_0001, 32'h0000_FFFF, 1'b1, 32'h0, 1, 0, 1'b1, 32'hA5A5_A5A5));
        vecs.push_back(mk(1'b0, 3'd3, 32'h0000_0040, 32'h0,         1'b1, 32'h0, 1, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0001_0000, 32'h0,         1'b1, 32'h0, 1, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'h1234_0010, 32'h0,         1'b1, 32'h0, 1, 0, 1'b1, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b1, 3'd4, 32'h0000_0020, 32'h0,         1'b1, 32'h0, 1, 0, 1'b1, 32'h11AA_5555));
        vecs.push_back(mk(1'b1, 3'd0, 32'h0000_0031, 32'h1234_5678, 1'b0, 32'h0, 2, 1, 1'b1, 32'h80FF_7801));
        vecs.push_back(mk(1'b1, 3'd1, 32'h0000_0032, 32'h0000_BEEF, 1'b0, 32'h0, 2, 1, 1'b1, 32'hBEEF_7801));
        vecs.push_back(mk(1'b0, 3'd1, 32'h0000_0032, 32'h0, 1'b0, 32'hFFFF_BEEF, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd5, 32'h0000_0032, 32'h0, 1'b0, 32'h0000_BEEF, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd4, 32'h0000_0031, 32'h0, 1'b0, 32'h0000_0078, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 3'd2, 32'h0000_0030, 32'h0, 1'b0, 32'hBEEF_7801, 2, 0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b1, 3'd2, 32'h0000_0050, 32'hCAFE_F00D, 1'b0, 32'h0, 1, 1, 1'b1, 32'hCAFE_F00D));

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_ready", {31'd0, req_ready}, 32'd1);
        check32("rst_valid", {31'd0, resp_valid}, 32'd0);
        check32("rst_err",   {31'd0, resp_err}, 32'd0);
        check32("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) do_op(i, vecs[i]);

        // Reset during the merge cycle of an SB must suppress the write.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h50; req_wdata = 32'h11;
        wen0 = wen_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check32("rmwrst_wen", {31'd0, ram_wen}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check32("rmwrst_ready", {31'd0, req_ready}, 32'd1);
        check32("rmwrst_valid", {31'd0, resp_valid}, 32'd0);
        check32("rmwrst_wcnt", wen_cnt - wen0, 32'd0);
        check32("rmwrst_mem", mem[14'h14], 32'hCAFE_F00D);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(100, mk(1'b0, 3'd2, 32'h50, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 0, 1'b0, 32'h0));

        // Back-to-back: req_valid is held high, and garbage is driven while the unit is busy.
        q_we[0] = 1'b1; q_f3[0] = 3'd2; q_addr[0] = 32'h60; q_wdata[0] = 32'h0102_0304; q_exp[0] = 32'h0;
        q_we[1] = 1'b0; q_f3[1] = 3'd4; q_addr[1] = 32'h61; q_wdata[1] = 32'h0;         q_exp[1] = 32'h3;
        q_we[2] = 1'b0; q_f3[2] = 3'd1; q_addr[2] = 32'h62; q_wdata[2] = 32'h0;         q_exp[2] = 32'h102;
        k = 0; r = 0; wen0 = wen_cnt;
        for (int cyc = 0; cyc < 40 && r < 3; cyc++) begin
            if (resp_valid) begin
                check32($sformatf("b2b%0d_err", r), {31'd0, resp_err}, 32'd0);
                check32($sformatf("b2b%0d_rdata", r), resp_rdata, q_exp[r]);
                r++;
            end
            acc = 0;
            if (k < 3) begin
                req_valid = 1'b1;
                if (req_ready) begin
                    req_we = q_we[k]; req_funct3 = q_f3[k]; req_addr = q_addr[k]; req_wdata = q_wdata[k];
                    acc = 1;
                    acc_cyc[k] = cyc;
                end else begin
                    req_we = 1'b1; req_funct3 = 3'd7; req_addr = 32'hFFFF_FFF3; req_wdata = 32'hFFFF_FFFF;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            if (acc == 1) k++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check32("b2b_count", r, 32'd3);
        check32("b2b_gap01", acc_cyc[1] - acc_cyc[0], 32'd2);
        check32("b2b_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
        check32("b2b_wens", wen_cnt - wen0, 32'd1);
        check32("b2b_mem", mem[14'h18], 32'h0102_0304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
